datapath_execute: RTL
=====================

// Module: datapath_execute
// PURPOSE
//  EX stage of the 16-bit pipelined CPU; consumes the ID_EX register written by the RF-read stage.
//  Executes ALU/move/compare and issues data-memory requests; resolves jumps and owns the Z/N flags.
//  Forwards operands and writes the EX_WB pipeline register; squashes the 2 wrong-path instrs after a taken jump.
// PARAMETERS
//  SQUASH_DEPTH  2  younger instrs already in IF/ID when a jump resolves in EX
// PORTS
//  clk           in   1   clock; single clock domain
//  reset         in   1   synchronous, active-high
//  ID_EX         in   96  {imm8s[95:80],imm11s[79:64],data1[63:48]=[Rx],data2[47:32]=[Ry],PC[31:16],instr[15:0]}
//  wb_we         in   1   WB stage writing RF this cycle
//  wb_addr       in   3   WB destination reg
//  wb_data       in   16  WB write data (ALU result or load data)
//  o_mem_addr    out  16  data-mem address (ld/st): [Ry]
//  o_mem_rd      out  1   ld issued (comb)
//  o_mem_wr      out  1   st issued (comb); o_mem_wrdata = [Rx]
//  o_mem_wrdata  out  16  store data
//  o_br_taken    out  1   redirect fetch this cycle (comb)
//  o_br_target   out  16  redirect target (comb)
//  o_flag_z      out  1   Z flag (reg)
//  o_flag_n      out  1   N flag (reg)
//  EX_WB         out  38  {valid[37],we[36],is_ld[35],wb_addr[34:32],result[31:16],instr[15:0]} (reg)
// BEHAVIOUR
//  Decode: op=instr[4:0], Rx=instr[7:5], Ry=instr[10:8]; PC field = address of the instr.
//  Ops: mv 00000, add 00001, sub 00010, cmp 00011, ld 00100, st 00101, mvi 10000, addi 10001,
//   subi 10010, cmpi 10011, mvhi 10110, jr 01000, jzr 01001, jnr 01010, callr 01100,
//   j 11000, jz 11001, jn 11010, call 11100; any other op = NOP (no write, no flags, no mem).
//  Operand forwarding, per operand, priority high->low:
//   1) EX_WB.valid & we & !is_ld & wb_addr==reg -> EX_WB.result
//   2) wb_we & wb_addr==reg -> wb_data
//   3) ID_EX data field
//  Load-use at distance 1 is the hazard unit's job. EX does not forward load data from EX_WB.
//  Arithmetic: 16-bit two's complement with wraparound; carry/overflow discarded.
//   mvhi result = {imm8s[7:0], opA[7:0]}.
//  Flags: add/sub/cmp/addi/subi/cmpi update Z=(res==0), N=res[15] at clk edge.
//   cmp/cmpi then write no register. All other ops hold the flags.
//  Jumps: reg forms target = fwd [Rx]; imm forms target = PC + 2 + (imm11s<<1), 16-bit wrap.
//   jz/jzr taken iff Z; jn/jnr taken iff N, using the flag value registered BEFORE this instr.
//   call/callr write PC+2 to r7.
//  Writes: mv/add/sub/addi/subi/mvi/mvhi -> Rx. ld -> Rx with is_ld=1 (result=addr; WB muxes mem data).
//   st/j*/cmp*/NOP -> we=0.
//  Squash: 2-bit counter sq_cnt.
//   Taken jump on a live instr -> sq_cnt <= SQUASH_DEPTH; otherwise it decrements to 0.
//   While sq_cnt!=0 the instr is dead: no mem req, no flags, no jump, EX_WB.valid=0/we=0.
//   A jump in a dead slot is ignored and does not reload the counter.
//  Latency: 1 cycle ID_EX -> EX_WB. mem/branch outputs are comb in the EX cycle.
//  Reset: EX_WB=0, Z=N=0, sq_cnt=0. mem_rd/wr=0 and br_taken=0 during reset.
//   Reset mid-squash clears the counter; the first post-reset instr is live.
//  ID_EX all-zero (mv r0,r0) is a legal live instr writing r0.
// STRUCTURE
//  definesPkg: ID_EX_WIDTH=96, EX_WB_WIDTH=38, opcode_t enum, field-offset localparams,
//   and packed struct ex_wb_t.
//  Sub-module alu16: op, a, b -> res, z, n; comb; shared by ALU ops and cmp.
//  Remainder in this module: forwarding muxes, flags, squash FSM, jump resolve, EX_WB register.
// TESTING
//  1) r1=5,r2=3: add r1,r2 -> EX_WB.result=8, wb_addr=1, we=1; Z=0,N=0.
//  2) cmpi r1,#5 with [r1]=5 -> Z=1, we=0; next jz +4 at PC=0x0010 -> br_taken=1, target=0x001A.
//  3) Taken j, then two instrs addi r3,#1 -> both EX_WB.valid=0, flags unchanged; third instr live.
//  4) addi r1,#1 then add r2,r1 back-to-back -> 2nd uses forwarded r1 (EX_WB), not stale ID_EX.
//  5) wb_we=1,wb_addr=4,wb_data=0x1234 with st r4,r5 -> o_mem_wrdata=0x1234, o_mem_wr=1.
//  6) Assert reset during squash (sq_cnt=1) -> EX_WB=0, Z=N=0, next add after reset commits.

Source files
------------

// File: rtl/datapath_execute_pkg.sv
// Shared types and field layout for the EX stage of the 16-bit pipelined CPU.
package datapath_execute_pkg;

    localparam int ID_EX_WIDTH = 96;
    localparam int EX_WB_WIDTH = 38;
    localparam int DATA_W      = 16;

    // Bit offsets of the fields packed into the ID_EX pipeline register
    localparam int INSTR_LSB = 0;
    localparam int PC_LSB    = 16;
    localparam int DATA2_LSB = 32;
    localparam int DATA1_LSB = 48;
    localparam int IMM11_LSB = 64;
    localparam int IMM8_LSB  = 80;

    // Link register written by call/callr
    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic [4:0] {
        OP_MV    = 5'b00000,
        OP_ADD   = 5'b00001,
        OP_SUB   = 5'b00010,
        OP_CMP   = 5'b00011,
        OP_LD    = 5'b00100,
        OP_ST    = 5'b00101,
        OP_MVI   = 5'b10000,
        OP_ADDI  = 5'b10001,
        OP_SUBI  = 5'b10010,
        OP_CMPI  = 5'b10011,
        OP_MVHI  = 5'b10110,
        OP_JR    = 5'b01000,
        OP_JZR   = 5'b01001,
        OP_JNR   = 5'b01010,
        OP_CALLR = 5'b01100,
        OP_J     = 5'b11000,
        OP_JZ    = 5'b11001,
        OP_JN    = 5'b11010,
        OP_CALL  = 5'b11100
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_PASS_B,
        ALU_MVHI
    } alu_op_t;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        is_ld;
        logic [2:0]  wb_addr;
        logic [15:0] result;
        logic [15:0] instr;
    } ex_wb_t;

endpackage

// File: rtl/datapath_execute_alu16.sv
// 16-bit ALU shared by the arithmetic, move and compare instructions.
module alu16
    import datapath_execute_pkg::*;
(
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              z,
    output logic              n
);

    // Result select; carry and overflow are intentionally dropped (wraparound)
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        res = '0;
        unique case (op)
            ALU_ADD:    res = a + b;
            ALU_SUB:    res = a - b;
            ALU_PASS_B: res = b;
            ALU_MVHI:   res = {b[7:0], a[7:0]};
            default:    res = '0;
        endcase
        z = (res == '0);
        n = res[DATA_W-1];
    end

endmodule

// File: rtl/datapath_execute.sv
// EX stage: operand forwarding, ALU, flags, memory request, jump resolve,
// wrong-path squash and the EX_WB pipeline register.
module datapath_execute
    import datapath_execute_pkg::*;
#(
    parameter int SQUASH_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ID_EX_WIDTH-1:0] ID_EX,
    input  logic                   wb_we,
    input  logic [2:0]             wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic [DATA_W-1:0]      o_mem_addr,
    output logic                   o_mem_rd,
    output logic                   o_mem_wr,
    output logic [DATA_W-1:0]      o_mem_wrdata,
    output logic                   o_br_taken,
    output logic [DATA_W-1:0]      o_br_target,
    output logic                   o_flag_z,
    output logic                   o_flag_n,
    output logic [EX_WB_WIDTH-1:0] EX_WB
);

    // ID_EX fields
    logic [DATA_W-1:0] instr, pc, data1, data2, imm11s, imm8s;
    logic [2:0]        rx, ry;
    opcode_t           op;

    assign instr  = ID_EX[INSTR_LSB +: DATA_W];
    assign pc     = ID_EX[PC_LSB    +: DATA_W];
    assign data2  = ID_EX[DATA2_LSB +: DATA_W];
    assign data1  = ID_EX[DATA1_LSB +: DATA_W];
    assign imm11s = ID_EX[IMM11_LSB +: DATA_W];
    assign imm8s  = ID_EX[IMM8_LSB  +: DATA_W];
    assign op     = opcode_t'(instr[4:0]);
    assign rx     = instr[7:5];
    assign ry     = instr[10:8];

    // State
    ex_wb_t     ex_wb_q, ex_wb_d;
    logic       flag_z_q, flag_z_d;
    logic       flag_n_q, flag_n_d;
    logic [1:0] sq_cnt_q, sq_cnt_d;

    // Forwarded operands and decode results
    logic [DATA_W-1:0] op_a, op_b, alu_b, alu_res, br_target;
    logic              alu_z, alu_n;
    alu_op_t           alu_op;
    logic              writes_rx, is_ld, sets_flags, mem_rd_op, mem_wr_op;
    logic              is_jump, jump_cond, jump_reg, is_call;
    logic              live, taken;

    // Load data is not yet available in EX_WB, so a load there is never forwarded
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [2:0]        r,
        input ex_wb_t            exq,
        input logic              wwe,
        input logic [2:0]        waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] rf
    );
        if (exq.valid && exq.we && !exq.is_ld && exq.wb_addr == r) return exq.result;
        else if (wwe && waddr == r)                                   return wdata;
        else                                                          return rf;
    endfunction

    assign op_a = fwd_sel(rx, ex_wb_q, wb_we, wb_addr, wb_data, data1);
    assign op_b = fwd_sel(ry, ex_wb_q, wb_we, wb_addr, wb_data, data2);

    alu16 u_alu (
        .op  (alu_op),
        .a   (op_a),
        .b   (alu_b),
        .res (alu_res),
        .z   (alu_z),
        .n   (alu_n)
    );

    // Instruction decode into ALU control, write-back, memory and jump controls
    always_comb begin
        alu_op     = ALU_ADD;
        alu_b      = op_b;
        writes_rx  = 1'b0;
        is_ld      = 1'b0;
        sets_flags = 1'b0;
        mem_rd_op  = 1'b0;
        mem_wr_op  = 1'b0;
        is_jump    = 1'b0;
        jump_cond  = 1'b1;
        jump_reg   = 1'b0;
        is_call    = 1'b0;
        case (op)
            OP_MV:    begin alu_op = ALU_PASS_B; writes_rx = 1'b1; end
            OP_ADD:   begin alu_op = ALU_ADD; writes_rx = 1'b1; sets_flags = 1'b1; end
            OP_SUB:   begin alu_op = ALU_SUB; writes_rx = 1'b1; sets_flags = 1'b1; end
            OP_CMP:   begin alu_op = ALU_SUB; sets_flags = 1'b1; end
            OP_LD:    begin is_ld = 1'b1; writes_rx = 1'b1; mem_rd_op = 1'b1; end
            OP_ST:    mem_wr_op = 1'b1;
            OP_MVI:   begin alu_op = ALU_PASS_B; alu_b = imm8s; writes_rx = 1'b1; end
            OP_ADDI:  begin alu_op = ALU_ADD; alu_b = imm8s; writes_rx = 1'b1; sets_flags = 1'b1; end
            OP_SUBI:  begin alu_op = ALU_SUB; alu_b = imm8s; writes_rx = 1'b1; sets_flags = 1'b1; end
            OP_CMPI:  begin alu_op = ALU_SUB; alu_b = imm8s; sets_flags = 1'b1; end
            OP_MVHI:  begin alu_op = ALU_MVHI; alu_b = imm8s; writes_rx = 1'b1; end
            OP_JR:    begin is_jump = 1'b1; jump_reg = 1'b1; end
            OP_JZR:   begin is_jump = 1'b1; jump_reg = 1'b1; jump_cond = flag_z_q; end
            OP_JNR:   begin is_jump = 1'b1; jump_reg = 1'b1; jump_cond = flag_n_q; end
            OP_CALLR: begin is_jump = 1'b1; jump_reg = 1'b1; is_call = 1'b1; end
            OP_J:     is_jump = 1'b1;
            OP_JZ:    begin is_jump = 1'b1; jump_cond = flag_z_q; end
            OP_JN:    begin is_jump = 1'b1; jump_cond = flag_n_q; end
            OP_CALL:  begin is_jump = 1'b1; is_call = 1'b1; end
            default:  ;
        endcase
    end

    assign live      = (sq_cnt_q == 2'd0);
    assign taken     = live && is_jump && jump_cond;
    assign br_target = jump_reg ? op_a : pc + 16'd2 + (imm11s << 1);

    // Next-state for EX_WB, flags and the squash counter
    always_comb begin
        ex_wb_d.valid   = live;
        ex_wb_d.we      = live && (writes_rx || is_call);
        ex_wb_d.is_ld   = live && is_ld;
        ex_wb_d.wb_addr = is_call ? LINK_REG : rx;
        ex_wb_d.result  = is_call ? pc + 16'd2 : (is_ld ? op_b : alu_res);
        ex_wb_d.instr   = instr;

        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        if (live && sets_flags) begin
            flag_z_d = alu_z;
            flag_n_d = alu_n;
        end

        sq_cnt_d = sq_cnt_q;
        if (taken)                 sq_cnt_d = 2'(SQUASH_DEPTH);
        else if (sq_cnt_q != 2'd0) sq_cnt_d = sq_cnt_q - 2'd1;
    end

    // Pipeline register, flags and squash counter with synchronous reset
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_wb_q  <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            sq_cnt_q <= 2'd0;
        end else begin
            ex_wb_q  <= ex_wb_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    assign o_mem_addr   = op_b;
    assign o_mem_wrdata = op_a;
    assign o_mem_rd     = live && mem_rd_op && !reset;
    assign o_mem_wr     = live && mem_wr_op && !reset;
    assign o_br_taken   = taken && !reset;
    assign o_br_target  = br_target;
    assign o_flag_z     = flag_z_q;
    assign o_flag_n     = flag_n_q;
    assign EX_WB        = ex_wb_q;

endmodule
